// File: rtl/sipo_gather_if.sv
// Handshake bundle for sipo_gather: word-serial input side and block output side.
// slave is the gatherer's view; master is the source/consumer view.
interface sipo_gather_if #(
    parameter int IN_W  = 8,
    parameter int SET_N = 16,
    parameter int OUT_W = IN_W * SET_N,
    parameter int CNT_W = $clog2(SET_N + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/sipo_gather.sv
// Serial-in/parallel-out gatherer: packs up to SET_N words of IN_W bits into
// one block, closing early on in_last, and holds the block until accepted.
module sipo_gather #(
    parameter int IN_W         = 8,
    parameter int SET_N        = 16,
    parameter int OUT_W        = IN_W * SET_N,
    parameter int CNT_W        = $clog2(SET_N + 1),
    parameter bit FIRST_AT_MSB = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    sipo_gather_if.slave   bus
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             last_in;
    logic             at_final_slot;
    logic             in_ready;
    logic             accept;
    logic             complete;
    logic             xfer;
    logic [OUT_W-1:0] acc_ins;

    // Bit offset of slot k within the block for the selected packing order.
    function automatic int unsigned slot_lsb(input int unsigned k);
        if (FIRST_AT_MSB)
            return (SET_N - 1 - k) * IN_W;
        else
            return k * IN_W;
    endfunction

    assign last_in       = bus.in_valid & bus.in_last;
    assign at_final_slot = (cnt_q == CNT_W'(SET_N - 1));
    // Only a word that would complete a block has to wait for the output register.
    assign in_ready      = ~out_valid_q | bus.out_ready | (~last_in & ~at_final_slot);
    assign accept        = bus.in_valid & in_ready;
    assign complete      = accept & (last_in | at_final_slot);
    assign xfer          = out_valid_q & bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

    // Accumulator with the incoming word merged into slot cnt.
    always_comb begin
        acc_ins = acc_q;
        for (int unsigned k = 0; k < SET_N; k++) begin
            if (cnt_q == CNT_W'(k))
                acc_ins[slot_lsb(k) +: IN_W] = bus.in_data;
        end
    end

    // Next-state: clear overrides; a completion in the same cycle as a transfer
    // reloads the output register so out_valid stays high.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (clear) begin
            cnt_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (xfer)
                out_valid_d = 1'b0;
            if (complete) begin
                out_data_d  = acc_ins;
                out_count_d = cnt_q + 1'b1;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else if (accept) begin
                acc_d = acc_ins;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

endmodule
